pattern_scan_ctrl: RTL
======================

Name: pattern_scan_ctrl

Overview:
Sequencer for the single-bit serial pattern detector (10110, Mealy, registered output).
- Accepts a frame of parallel words over a valid/ready handshake.
- Serializes the words into the detector's valid/in inputs as one contiguous bit stream.
- Resets the detector at frame start, counts detector hits, and reports completion.
- Sits between the word-oriented upstream datapath and the detector instance.

Parameters:
- WORD_W, 8: bits per input word.
- LEN_W, 8: width of the frame length (word count).
- CNT_W, 16: width of the hit counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame start request; sampled in IDLE only.
- frame_len  input  LEN_W  words in the frame; sampled with start.
- word_valid  input  1  upstream word available.
- word_data  input  WORD_W  upstream word.
- word_ready  output  1  controller accepts word_data this cycle.
- det_rst  output  1  synchronous reset pulse to the detector.
- det_valid  output  1  detector valid.
- det_in  output  1  detector serial bit.
- det_out  input  1  detector hit; registered, one cycle after the final pattern bit.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- hit_count  output  CNT_W  hits in current/last frame.
- underrun  output  1  sticky flag; a bit-stream gap occurred in the frame.

Behaviour:
- Reset (async): state IDLE. All outputs 0, including hit_count and underrun; shift register and counters 0.
- All outputs are registered, except word_ready, which is decoded from state.
- A word transfers when word_valid && word_ready at a rising edge.
- States: IDLE, LOAD, SHIFT, DRAIN.
- IDLE:
  - start with frame_len != 0: clear hit_count and underrun, pulse det_rst for 1 cycle, latch words_left = frame_len, go to LOAD.
  - start with frame_len == 0: done pulses next cycle, hit_count = 0, stay IDLE.
  - start while not IDLE is ignored.
- LOAD:
  - word_ready = 1, det_valid = 0.
  - On transfer: load the shift register, decrement words_left, set bit_idx = WORD_W-1, go to SHIFT.
- SHIFT:
  - det_valid = 1; det_in = shift register MSB; shift left each cycle.
  - On the last bit (bit_idx == 0) with words_left != 0: word_ready = 1, so the prefetch keeps the stream contiguous.
    - Transfer: reload and stay in SHIFT. No bubble; the detector state carries across the word boundary.
    - No transfer: go to LOAD and set underrun = 1. det_valid drops, which resets the detector, so partial patterns are lost by design.
  - On the last bit with words_left == 0: go to DRAIN.
- DRAIN:
  - det_valid = 0 for one cycle, to catch the final registered det_out.
  - Then go to IDLE; done = 1 and busy = 0 in the following cycle.
- Counting: hit_count increments on every edge where det_out == 1 and state is LOAD, SHIFT or DRAIN. It saturates at all-ones and holds until the next accepted start.
- busy = 1 in LOAD, SHIFT and DRAIN.
- Reset mid-frame aborts immediately: no done pulse, all counters cleared.
- A frame of N words with no underrun occupies 1 + N·WORD_W + 1 cycles after the first word transfer.

Optional Feature:
- Macro: PATTERN_SCAN_CTRL_LSB_FIRST_EN.
- Defined: words are serialized LSB first (det_in = shift register LSB, shift right).
- Undefined: MSB first.
- The handshake, timing and counting are identical in both builds.

Decomposition:
- Package pattern_scan_pkg holds:
  - state encoding constants (IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DRAIN = 2'd3);
  - default WORD_W, LEN_W and CNT_W constants.
- One natural sub-module, pattern_bit_serializer: shift register, bit index, load/shift controls, last_bit flag.
- The FSM, word counter and hit counter stay in the top.

Test Plan:
- Default build, detector attached, 1 word 0xB0 with word_valid held → bits 1,0,1,1,0,… → hit_count = 1, done pulses 10 cycles after the transfer, underrun = 0.
- 2 words 0x05, 0x60 supplied back-to-back → hit spans the word boundary → hit_count = 1, underrun = 0.
- Same two words with a 3-cycle word_valid gap before 0x60 → underrun = 1 and hit_count = 0; det_valid is low for the gap cycles.
- start with frame_len = 0 → done pulses next cycle, hit_count = 0, busy never asserts.
- rst asserted mid-SHIFT of a 4-word frame → all outputs 0 asynchronously, no done pulse; a following 1-word 0x5A frame gives hit_count = 1.
- With PATTERN_SCAN_CTRL_LSB_FIRST_EN: word 0x0D (LSB-first 1,0,1,1,0,…) → hit_count = 1.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared constants for the pattern scan controller: FSM state encoding
// and default widths.
package pattern_scan_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_scan_ctrl_serializer.sv
// Word-to-bit serializer: holds the current word, walks a bit index down
// to zero and flags the last bit so the controller can prefetch.
// Bit order: MSB first by default, LSB first when
// PATTERN_SCAN_CTRL_LSB_FIRST_EN is defined.
module pattern_bit_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sr;
  logic [IDX_W-1:0]  idx;

  // Load wins over shift so a prefetched word replaces the spent one seamlessly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= word;
      idx <= IDX_W'(WORD_W - 1);
    end else if (shift) begin
`ifdef PATTERN_SCAN_CTRL_LSB_FIRST_EN
      sr  <= sr >> 1;
`else
      sr  <= sr << 1;
`endif
      idx <= idx - 1'b1;
    end
  end

`ifdef PATTERN_SCAN_CTRL_LSB_FIRST_EN
  assign bit_out = sr[0];
`else
  assign bit_out = sr[WORD_W-1];
`endif

  assign last_bit = (idx == '0);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame sequencer for the serial 10110 detector: accepts words over
// valid/ready, streams them as one contiguous bit stream, counts hits and
// pulses done at frame end. Optional build macro
// PATTERN_SCAN_CTRL_LSB_FIRST_EN selects LSB-first serialization.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              det_rst,
  output logic              det_valid,
  output logic              det_in,
  input  logic              det_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic              underrun
);

  state_e           state;
  logic [LEN_W-1:0] words_left;
  logic             last_bit;
  logic             xfer;

  // Ready in LOAD, and on the final bit of a word when more words are owed
  always_comb begin
    word_ready = (state == LOAD) ||
                 ((state == SHIFT) && last_bit && (words_left != '0));
  end

  assign xfer = word_valid && word_ready;

  pattern_bit_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (xfer),
    .shift    (state == SHIFT),
    .word     (word_data),
    .bit_out  (det_in),
    .last_bit (last_bit)
  );

  // Frame FSM with word counter, saturating hit counter and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      words_left <= '0;
      det_rst    <= 1'b0;
      det_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_count  <= '0;
      underrun   <= 1'b0;
    end else begin
      det_rst <= 1'b0;
      done    <= 1'b0;
      if (det_out && (state != IDLE) && (hit_count != {CNT_W{1'b1}}))
        hit_count <= hit_count + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            hit_count <= '0;
            if (frame_len != '0) begin
              underrun   <= 1'b0;
              det_rst    <= 1'b1;
              words_left <= frame_len;
              busy       <= 1'b1;
              state      <= LOAD;
            end else begin
              done <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            words_left <= words_left - 1'b1;
            det_valid  <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (words_left != '0) begin
              if (xfer) begin
                words_left <= words_left - 1'b1;
              end else begin
                // Stream gap: dropping det_valid clears the detector's history
                det_valid <= 1'b0;
                underrun  <= 1'b1;
                state     <= LOAD;
              end
            end else begin
              det_valid <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
